// File: rtl/neopixel_pkg.sv
// Shared types and default timing for the WS2812 ("NeoPixel") serial driver.
// Timing defaults assume a 50 MHz system clock.
//   np_state_t : frame-level FSM states of the driver
//   grb_t      : one pixel word, {G[7:0], R[7:0], B[7:0]}, sent MSB first
package neopixel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    NEXT  = 2'd2,
    LATCH = 2'd3
  } np_state_t;

  typedef logic [23:0] grb_t;

  localparam int DEFAULT_NUM_PIXELS   = 8;
  localparam int DEFAULT_T0H          = 20;    // 0.4 us
  localparam int DEFAULT_T1H          = 40;    // 0.8 us
  localparam int DEFAULT_BIT_CYCLES   = 63;    // 1.26 us
  localparam int DEFAULT_RESET_CYCLES = 2600;  // 52 us latch

  localparam logic [4:0] LAST_BIT_INDEX = 5'd23;

endpackage

// File: rtl/neopixel_bit_encoder.sv
// Single-bit WS2812 waveform generator.
// Counts the cycles of one bit period and drives the registered line high for
// T0H or T1H cycles depending on the bit value, low for the rest.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   start        : restart the bit-cycle counter (a new pixel was accepted)
//   enable       : a bit is being transmitted this cycle
//   bit_value    : value of the bit currently being transmitted
//   dout         : registered serial output
//   last_cycle   : high in the final cycle of the current bit period
module neopixel_bit_encoder
  import neopixel_pkg::*;
#(
  parameter int T0H        = DEFAULT_T0H,
  parameter int T1H        = DEFAULT_T1H,
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic enable,
  input  logic bit_value,
  output logic dout,
  output logic last_cycle
);

  localparam int CYC_W = $clog2(BIT_CYCLES);
  localparam logic [CYC_W-1:0] T0H_C      = CYC_W'(T0H);
  localparam logic [CYC_W-1:0] T1H_C      = CYC_W'(T1H);
  localparam logic [CYC_W-1:0] LAST_CYC_C = CYC_W'(BIT_CYCLES - 1);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] high_cycles;
  logic             dout_q, dout_d;

  // The line level for the next cycle is decided from the current count, so
  // the waveform on dout trails the counter by one cycle.
  always_comb begin
    high_cycles = bit_value ? T1H_C : T0H_C;
    last_cycle  = enable && (cyc_q == LAST_CYC_C);
    cyc_d       = cyc_q;
    dout_d      = 1'b0;
    if (start) begin
      cyc_d = '0;
    end else if (enable) begin
      dout_d = (cyc_q < high_cycles);
      cyc_d  = last_cycle ? '0 : cyc_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cyc_q  <= cyc_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/neopixel_driver.sv
// WS2812 frame driver: accepts NUM_PIXELS GRB words per frame over a
// valid/ready handshake and serializes them MSB first, then holds the line
// low for the latch period and pulses frame_done.
// Ports:
//   clock, reset  : system clock, asynchronous active-high reset
//   pixel_data    : {G,R,B} pixel word, captured on handshake
//   pixel_valid   : upstream offers a pixel
//   pixel_ready   : driver accepts a pixel this cycle (IDLE or NEXT)
//   dout          : registered serial line to the strip
//   busy          : a frame is in progress
//   frame_done    : one-cycle pulse once the latch period has elapsed
//   underrun      : one-cycle pulse when a missing pixel aborts the frame
module neopixel_driver
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS   = DEFAULT_NUM_PIXELS,
  parameter int T0H          = DEFAULT_T0H,
  parameter int T1H          = DEFAULT_T1H,
  parameter int BIT_CYCLES   = DEFAULT_BIT_CYCLES,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int WAIT_W = $clog2(RESET_CYCLES + 1);
  localparam int PIX_W  = $clog2(NUM_PIXELS + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST_C = WAIT_W'(RESET_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_END_C  = WAIT_W'(RESET_CYCLES);
  localparam logic [PIX_W-1:0]  LAST_PIX_C  = PIX_W'(NUM_PIXELS - 1);

  np_state_t         state_q, state_d;
  grb_t              shreg_q, shreg_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              underrun_q, underrun_d;

  logic accept;
  logic bit_last_cycle;

  assign pixel_ready = (state_q == IDLE) || (state_q == NEXT);
  assign accept      = pixel_valid && pixel_ready;
  assign busy        = (state_q != IDLE);

  neopixel_bit_encoder #(
    .T0H        (T0H),
    .T1H        (T1H),
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_encoder (
    .clock      (clock),
    .reset      (reset),
    .start      (accept),
    .enable     (state_q == SEND),
    .bit_value  (shreg_q[23]),
    .dout       (dout),
    .last_cycle (bit_last_cycle)
  );

  // The wait counter is shared: in NEXT it times out a stalled upstream, in
  // LATCH it measures the latch gap. LATCH runs one extra cycle past
  // RESET_CYCLES so that frame_done is raised while pixel_ready is still low.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (accept) begin
          shreg_d   = pixel_data;
          bit_cnt_d = LAST_BIT_INDEX;
          pix_cnt_d = '0;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (bit_last_cycle) begin
          if (bit_cnt_q != 5'd0) begin
            shreg_d   = {shreg_q[22:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 5'd1;
          end else if (pix_cnt_q == LAST_PIX_C) begin
            wait_cnt_d = '0;
            state_d    = LATCH;
          end else begin
            pix_cnt_d  = pix_cnt_q + 1'b1;
            wait_cnt_d = '0;
            state_d    = NEXT;
          end
        end
      end

      NEXT: begin
        // An accept on the timeout cycle takes priority over the underrun.
        if (accept) begin
          shreg_d    = pixel_data;
          bit_cnt_d  = LAST_BIT_INDEX;
          wait_cnt_d = '0;
          state_d    = SEND;
        end else if (wait_cnt_q == WAIT_LAST_C) begin
          underrun_d = 1'b1;
          wait_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      LATCH: begin
        if (wait_cnt_q == WAIT_END_C) begin
          wait_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          frame_done_d = (wait_cnt_q == WAIT_LAST_C);
          wait_cnt_d   = wait_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_neopixel_driver.sv
// Self-checking bench for neopixel_driver with a short-timing configuration.
// A frame-level reference model derives, for every cycle of a frame, the
// expected {dout, pixel_ready, busy, frame_done, underrun} from the pixel
// words and the moment the second pixel is offered.
module tb_neopixel_driver;

  localparam int NUM_PIXELS   = 2;
  localparam int T0H          = 2;
  localparam int T1H          = 4;
  localparam int BIT_CYCLES   = 6;
  localparam int RESET_CYCLES = 20;

  // Cycle 0 is the cycle in which the first pixel is offered; that pixel is
  // sent in cycles 1..PIXEL_CYCLES and the line follows one cycle later.
  localparam int PIXEL_CYCLES = 24 * BIT_CYCLES;
  localparam int NEXT0        = 1 + PIXEL_CYCLES;
  localparam int UNDERRUN_T   = NEXT0 + RESET_CYCLES;

  logic        clock;
  logic        reset;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        dout;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  int errorCount = 0;
  int checkCount = 0;

  neopixel_driver #(
    .NUM_PIXELS   (NUM_PIXELS),
    .T0H          (T0H),
    .T1H          (T1H),
    .BIT_CYCLES   (BIT_CYCLES),
    .RESET_CYCLES (RESET_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .dout        (dout),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [23:0] data);
    pixel_valid = valid;
    pixel_data  = data;
  endtask

  function automatic logic [4:0] observed();
    return {dout, pixel_ready, busy, frame_done, underrun};
  endfunction

  // Line level k cycles into a pixel's waveform: bit k/BIT_CYCLES counted
  // from the G7 end, high for T1H or T0H cycles of its period.
  function automatic logic pixelLevel(input logic [23:0] p, input int k);
    logic [23:0] word;
    int bitIdx;
    word   = p;
    bitIdx = 23 - (k / BIT_CYCLES);
    return (k % BIT_CYCLES) < (word[bitIdx] ? T1H : T0H);
  endfunction

  // gap = cycles the second pixel is withheld once the driver asks for it;
  // negative or >= RESET_CYCLES means it never arrives in time.
  function automatic logic [4:0] expectedVec(input int t, input int gap,
                                             input logic [23:0] p0,
                                             input logic [23:0] p1);
    bit   under;
    int   t1;
    int   doneT;
    logic eDout, eReady, eBusy, eDone, eUnder;
    under  = (gap < 0) || (gap >= RESET_CYCLES);
    t1     = NEXT0 + 1 + gap;
    doneT  = t1 + PIXEL_CYCLES + RESET_CYCLES;
    eDout  = 1'b0;
    eDone  = 1'b0;
    eUnder = 1'b0;
    if (t >= 2 && t <= NEXT0) eDout = pixelLevel(p0, t - 2);
    if (!under && t > t1 && t <= t1 + PIXEL_CYCLES) eDout = pixelLevel(p1, t - t1 - 1);
    if (under) begin
      eBusy  = (t >= 1) && (t < UNDERRUN_T);
      eReady = !((t >= 1) && (t < NEXT0));
      eUnder = (t == UNDERRUN_T);
    end else begin
      eBusy  = (t >= 1) && (t <= doneT);
      eReady = !(((t >= 1) && (t < NEXT0)) || ((t >= t1) && (t <= doneT)));
      eDone  = (t == doneT);
    end
    return {eDout, eReady, eBusy, eDone, eUnder};
  endfunction

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1 applyStimulus(1'b0, 24'($urandom));
      @(negedge clock);
      checkOutput($sformatf("%s[%0d]", tag, i), 32'(observed()), 32'(5'b01000));
    end
  endtask

  // Runs one frame from an idle driver, checking every cycle. With toggle set,
  // pixel_valid and pixel_data are randomized whenever the driver should not
  // be accepting. stopAt >= 0 ends the run early after that cycle.
  task automatic runFrame(input logic [23:0] p0, input logic [23:0] p1,
                          input int gap, input bit toggle, input int stopAt);
    bit         under;
    int         lastT;
    logic [4:0] e;
    under = (gap < 0) || (gap >= RESET_CYCLES);
    lastT = under ? UNDERRUN_T + 3 : NEXT0 + 1 + gap + PIXEL_CYCLES + RESET_CYCLES + 3;
    if (stopAt >= 0) lastT = stopAt;
    for (int t = 0; t <= lastT; t++) begin
      e = expectedVec(t, gap, p0, p1);
      @(posedge clock);
      #1;
      if (t == 0)
        applyStimulus(1'b1, p0);
      else if (!under && t == NEXT0 + gap)
        applyStimulus(1'b1, p1);
      else if (toggle && !e[3])
        applyStimulus(1'($urandom), 24'($urandom));
      else
        applyStimulus(1'b0, 24'($urandom));
      @(negedge clock);
      checkOutput($sformatf("frame t=%0d", t), 32'(observed()), 32'(e));
    end
  endtask

  initial begin
    logic [23:0] p0;
    logic [23:0] p1;

    reset = 1'b1;
    applyStimulus(1'b0, 24'h0);
    repeat (2) @(negedge clock);
    checkOutput("resetState", 32'(observed()), 32'(5'b01000));
    reset = 1'b0;
    idleCycles(30, "idle");

    $display("[TB] frame 800000/000001 back-to-back");
    runFrame(24'h800000, 24'h000001, 0, 1'b0, -1);

    $display("[TB] stalled second pixel -> underrun");
    runFrame(24'($urandom), 24'h0, -1, 1'b0, -1);
    idleCycles(5, "afterUnderrun");

    $display("[TB] second pixel on the timeout cycle");
    runFrame(24'($urandom), 24'($urandom), RESET_CYCLES - 1, 1'b0, -1);

    $display("[TB] reset in the middle of bit 10");
    p0 = 24'($urandom) | 24'h002000;
    p1 = 24'($urandom);
    runFrame(p0, p1, 0, 1'b0, 64);
    @(posedge clock);
    #1 applyStimulus(1'b0, 24'h0);
    #2 checkOutput("preReset", 32'(observed()), 32'(expectedVec(65, 0, p0, p1)));
    reset = 1'b1;
    #1 checkOutput("asyncReset", 32'(observed()), 32'(5'b01000));
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idleCycles(5, "postReset");
    runFrame(24'hFFFFFF, 24'hFFFFFF, 0, 1'b0, -1);

    $display("[TB] valid toggling while busy");
    for (int f = 0; f < 3; f++) begin
      runFrame(24'($urandom), 24'($urandom), int'($urandom_range(0, 5)), 1'b1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
